crc_chk: RTL and testbench

- Serial CRC checker (receive end) for the team's serial LFSR CRC generator.
- Consumes a frame: payload bits LSB-first while ACTIVE is high, then CRC_WD received CRC bits LSB-first while CRC_VALID is high.
- Recomputes the CRC with the same LFSR (seed, taps, bit order) and compares it bit-by-bit against the received CRC.
- Reports pass/fail and framing errors to the downstream receive controller.

---
 rtl/crc_chk.sv | 123 ++++++++++++
 tb/tb_crc_chk.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/crc_chk.sv
// Serial CRC checker: recomputes the LFSR CRC over an LSB-first payload and
// compares it bit-by-bit against the received LSB-first CRC, reporting pass/fail/framing.
module crc_chk #(
  parameter int unsigned       CRC_WD = 8,
  parameter logic [CRC_WD-1:0] SEED   = 8'hD8,
  parameter logic [CRC_WD-1:0] TAPS   = 8'b0100_0100
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA,
  input  logic ACTIVE,
  input  logic CRC_IN,
  input  logic CRC_VALID,
  output logic BUSY,
  output logic DONE,
  output logic PASS,
  output logic CRC_ERR,
  output logic FRM_ERR
);

  localparam int unsigned CW = $clog2(CRC_WD) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK, S_DONE} state_t;

  state_t            r_state;
  logic [CRC_WD-1:0] r_lfsr;
  logic [CW-1:0]     r_cnt;
  logic              r_mis;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_crc_err;
  logic              r_frm_err;

  logic w_mis_nxt;
  logic w_last;
  logic w_frm_err;

  // The MSB only ever receives the feedback itself, so its tap bit is masked off.
  function automatic logic [CRC_WD-1:0] f_step(input logic [CRC_WD-1:0] s, input logic d);
    logic fb;
    fb = d ^ s[0];
    return {fb, s[CRC_WD-1:1]} ^ (TAPS & {1'b0, {(CRC_WD-1){fb}}});
  endfunction

  assign w_mis_nxt = r_mis | (CRC_IN ^ r_lfsr[0]);
  assign w_last    = (r_cnt == CW'(CRC_WD - 1));
  assign w_frm_err = (ACTIVE && CRC_VALID) ||
                     ((r_state == S_CHECK) && (ACTIVE || !CRC_VALID));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_cnt     <= '0;
      r_mis     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_crc_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ACTIVE) begin
            r_lfsr    <= f_step(SEED, DATA);
            r_pass    <= 1'b0;
            r_crc_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_mis     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_DATA;
          end else if (CRC_VALID) begin
            r_frm_err <= 1'b1;
            r_pass    <= 1'b0;
            r_crc_err <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        // DATA and CHECK share the CRC-bit path: the first CRC bit is consumed on
        // the DATA->CHECK transition cycle itself.
        S_DATA, S_CHECK: begin
          if (w_frm_err) begin
            r_frm_err <= 1'b1;
            r_pass    <= 1'b0;
            r_crc_err <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else if (ACTIVE) begin
            r_lfsr <= f_step(r_lfsr, DATA);
          end else if (CRC_VALID) begin
            r_mis   <= w_mis_nxt;
            r_lfsr  <= {1'b0, r_lfsr[CRC_WD-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            r_state <= S_CHECK;
            if (w_last) begin
              r_pass    <= ~w_mis_nxt;
              r_crc_err <= w_mis_nxt;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_lfsr  <= SEED;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign PASS    = r_pass;
  assign CRC_ERR = r_crc_err;
  assign FRM_ERR = r_frm_err;

endmodule

// File: tb/tb_crc_chk.sv
// Directed bench for crc_chk: frames are driven linearly, expected results are queued
// with the cycle DONE must appear on, and a negedge monitor pops and checks them.
module tb_crc_chk;

  logic CLK = 1'b0;
  logic RST;
  logic DATA, ACTIVE, CRC_IN, CRC_VALID;
  logic BUSY, DONE, PASS, CRC_ERR, FRM_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int   cyc;
    logic p;
    logic ce;
    logic fe;
  } exp_t;
  exp_t q[$];

  crc_chk #(.CRC_WD(8), .SEED(8'hD8), .TAPS(8'b0100_0100)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE), .CRC_IN(CRC_IN),
    .CRC_VALID(CRC_VALID), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .CRC_ERR(CRC_ERR), .FRM_ERR(FRM_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC: seed D8, feedback into bit 7, extra XOR into bits 6 and 2.
  function automatic logic [7:0] crc_model(input logic [31:0] p, input int n);
    logic [7:0] s;
    logic fb;
    s = 8'hD8;
    for (int i = 0; i < n; i++) begin
      fb = p[i] ^ s[0];
      s  = {fb, s[7:1]};
      if (fb) s = s ^ 8'h44;
    end
    return s;
  endfunction

  task automatic drive(input logic a, input logic d, input logic v, input logic c);
    @(posedge CLK);
    #1;
    ACTIVE = a; DATA = d; CRC_VALID = v; CRC_IN = c;
  endtask

  task automatic frame(input logic [31:0] pay, input int plen, input logic [7:0] crc,
                       input int ncrc, input int gap, input logic ep, input logic ece,
                       input logic efe, input bit hold);
    int t;
    int total;
    total = plen + gap + ncrc;
    for (int k = 0; k < total; k++) begin
      if (k < plen)            drive(1'b1, pay[k], 1'b0, 1'b0);
      else if (k < plen + gap) drive(1'b0, 1'b0, 1'b0, 1'b0);
      else                     drive(1'b0, 1'b0, 1'b1, crc[k-plen-gap]);
      if (k == 1) begin
        chk("busy_in_frame", {31'b0, BUSY}, 32'd1);
        chk("pass_cleared", {31'b0, PASS}, 32'd0);
        chk("crc_err_cleared", {31'b0, CRC_ERR}, 32'd0);
        chk("frm_err_cleared", {31'b0, FRM_ERR}, 32'd0);
      end
    end
    t = cyc;
    q.push_back('{t + ((ncrc < 8) ? 2 : 1), ep, ece, efe});
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (ncrc < 8) drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (hold) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_pass", {31'b0, PASS}, {31'b0, ep});
      chk("hold_crc_err", {31'b0, CRC_ERR}, {31'b0, ece});
      chk("hold_frm_err", {31'b0, FRM_ERR}, {31'b0, efe});
      chk("hold_done_low", {31'b0, DONE}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, BUSY}, 32'd0);
    chk({tag, "_done"}, {31'b0, DONE}, 32'd0);
    chk({tag, "_pass"}, {31'b0, PASS}, 32'd0);
    chk({tag, "_crc_err"}, {31'b0, CRC_ERR}, 32'd0);
    chk({tag, "_frm_err"}, {31'b0, FRM_ERR}, 32'd0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1) begin
      if (DONE === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_done", {31'b0, DONE}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("pass", {31'b0, PASS}, {31'b0, e.p});
          chk("crc_err", {31'b0, CRC_ERR}, {31'b0, e.ce});
          chk("frm_err", {31'b0, FRM_ERR}, {31'b0, e.fe});
          chk("busy_at_done", {31'b0, BUSY}, 32'd0);
        end
      end else if (q.size() != 0 && cyc >= q[0].cyc) begin
        chk("done_at_expected_cycle", {31'b0, DONE}, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp;
    int t;
    RST = 1'b0; DATA = 1'b0; ACTIVE = 1'b0; CRC_IN = 1'b0; CRC_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Good, bad, then good again: CRC_ERR must clear on the next frame.
    frame(32'h00, 8, 8'h14, 8, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(32'h00, 8, 8'h15, 8, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    frame(32'h00, 8, 8'h14, 8, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    // CRC_VALID drops after 5 bits.
    frame(32'h00, 8, 8'h14, 5, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    // 3-cycle gap between payload and CRC.
    frame(32'h00, 8, 8'h14, 8, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    // Back-to-back: ACTIVE on the cycle right after DONE.
    frame(32'h00, 8, 8'h14, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(32'h00, 8, 8'h14, 8, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-payload: asynchronous clear, no DONE pulse.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("busy_before_reset", {31'b0, BUSY}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("held_reset");
    RST = 1'b1;
    frame(32'h00, 8, 8'h14, 8, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Model-derived frames: random 13-bit payload, 1-bit payload, and MSB CRC flip.
    rp = $urandom;
    frame(rp, 13, crc_model(rp, 13), 8, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(32'h1, 1, crc_model(32'h1, 1), 8, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    rp = $urandom;
    frame(rp, 20, crc_model(rp, 20) ^ 8'h80, 8, 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // CRC_VALID with no payload while idle.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    t = cyc;
    q.push_back('{t + 1, 1'b0, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_frm_err_held", {31'b0, FRM_ERR}, 32'd1);

    // ACTIVE and CRC_VALID together during payload.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    t = cyc;
    q.push_back('{t + 1, 1'b0, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // ACTIVE reasserted during the CRC phase.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    t = cyc;
    q.push_back('{t + 1, 1'b0, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    frame(32'h00, 8, 8'h14, 8, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
